seq_div_8x4: RTL
================

SEQ_DIV_8X4 -- requirements
Module: seq_div_8x4

Interface
REQ-001: The block SHALL have one clock and an asynchronous, active-high reset, with ports listed clock first, then reset.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: start  input  1  request; sampled only in IDLE.
REQ-005: dividend  input  8  unsigned numerator; same width as the ALU's 8-bit product.
REQ-006: divisor  input  4  unsigned denominator; same width as the ALU operands.
REQ-007: quotient  output  8  unsigned quotient, registered.
REQ-008: remainder  output  4  unsigned remainder, registered.
REQ-009: busy  output  1  high whenever the state is not IDLE.
REQ-010: done  output  1  one-cycle pulse; results are valid while it is high.
REQ-011: div_by_zero  output  1  set when the last accepted divisor was 0.

Function
REQ-012: The state machine SHALL have the states IDLE, BUSY and DONE.
REQ-013: In IDLE, start=1 at edge k SHALL latch dividend and divisor, clear div_by_zero, and enter BUSY with an iteration count of 0.
REQ-014: In BUSY, each edge SHALL perform one restoring step, MSB first.
  - Form a 5-bit trial value: partial remainder shifted left by 1, with the next dividend bit as its LSB.
  - If the trial value is >= divisor, subtract the divisor and set the quotient bit to 1; otherwise set it to 0.
REQ-015: After the 8th step (edge k+8), the block SHALL be in DONE with done=1 for exactly one cycle, then return to IDLE at edge k+9.
REQ-016: quotient and remainder SHALL update only on entry to DONE and hold their values until the next DONE.
REQ-017: A divisor of 0 SHALL skip the iterations and enter DONE at edge k+1 with:
  - quotient=8'hFF
  - remainder=dividend[3:0]
  - div_by_zero=1
REQ-018: start while in BUSY or DONE SHALL be ignored; it is neither queued nor allowed to alter the latched operands.
REQ-019: Changes to dividend or divisor after acceptance SHALL NOT affect the operation in progress.
REQ-020: Results SHALL satisfy quotient*divisor + remainder == dividend, with remainder < divisor, for every divisor != 0.
REQ-021: busy SHALL be 1 from after edge k through the DONE cycle inclusive.

Reset
REQ-022: Asserting rst SHALL immediately force the following, regardless of the clock:
  - state=IDLE
  - quotient=0, remainder=0
  - busy=0, done=0, div_by_zero=0
  - all internal registers cleared
REQ-023: Reset during BUSY SHALL abort the operation with no done pulse; after release, the first start SHALL behave as from power-up.
REQ-024: start high in the first edge after reset release SHALL be accepted normally.

Structure
REQ-025: A shared package SHALL hold the state enum (IDLE, BUSY, DONE) and the constants DIVIDEND_W=8, DIVISOR_W=4, ITER_N=8 and DIV0_QUOT=8'hFF.
REQ-026: One combinational sub-module, div_step, SHALL implement a single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: next partial remainder and the quotient bit.
REQ-027: The top level SHALL hold only the FSM, the iteration counter, and the operand and result registers.

Verification
REQ-028: dividend=200, divisor=7, start pulse -> done at edge k+8; quotient=28, remainder=4, div_by_zero=0.
REQ-029: dividend=10, divisor=3 -> quotient=3, remainder=1, matching the 4-bit ALU modulo result (10 % 3 = 1); dividend=255, divisor=1 -> quotient=255, remainder=0.
REQ-030: dividend=5, divisor=0 -> done at edge k+1; quotient=8'hFF, remainder=5, div_by_zero=1; the next 9/2 -> quotient=4, remainder=1, div_by_zero=0.
REQ-031: Start 100/9, then at edge k+3 assert start with 50/5 and change the inputs -> a single done with quotient=11, remainder=1; the second request is dropped.
REQ-032: Reset asserted at edge k+4 of a 200/7 operation -> all outputs 0 immediately and no done pulse; 15/4 started after release -> quotient=3, remainder=3.
REQ-033: Random regression (at least 2000 pairs, back-to-back starts in IDLE) -> every result satisfies REQ-020, and done is never high for two consecutive cycles.

Source files
------------

// File: rtl/seq_div_8x4_pkg.sv
// Shared types and constants for the 8-bit by 4-bit sequential restoring divider.
package seq_div_8x4_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int ITER_N     = 8;
    localparam int CNT_W      = $clog2(ITER_N);

    localparam logic [DIVIDEND_W-1:0] DIV0_QUOT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div_8x4_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
// Purely combinational; the caller guarantees the incoming partial remainder is below the divisor.
module div_step
    import seq_div_8x4_pkg::*;
(
    input  logic [DIVISOR_W-1:0] i_rem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W-1:0] o_rem,
    output logic                 o_q_bit
);

    logic [DIVISOR_W:0] w_trial;

    assign w_trial = {i_rem, i_bit};
    assign o_q_bit = (w_trial >= {1'b0, i_divisor});
    // The difference is below the divisor, so only the low bits are needed.
    assign o_rem   = o_q_bit ? (w_trial[DIVISOR_W-1:0] - i_divisor) : w_trial[DIVISOR_W-1:0];

endmodule

// File: rtl/seq_div_8x4.sv
// Sequential 8/4 unsigned divider: result 8 edges after start (1 edge for divide-by-zero).
// start is honoured only in IDLE; requests during BUSY/DONE are dropped, not queued.
module seq_div_8x4
    import seq_div_8x4_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [DIVIDEND_W-1:0]   r_work;
    logic [DIVISOR_W-1:0]    r_dvs;
    logic [DIVISOR_W-1:0]    r_prem;
    logic [DIVIDEND_W-1:0]   r_quot;
    logic [DIVISOR_W-1:0]    r_rem;
    logic                    r_dbz;

    logic [DIVISOR_W-1:0]    w_rem_nxt;
    logic                    w_q_bit;
    logic                    w_last;
    logic                    w_dvs_zero;

    div_step u_step (
        .i_rem     (r_prem),
        .i_bit     (r_work[DIVIDEND_W-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_nxt),
        .o_q_bit   (w_q_bit)
    );

    assign w_last     = (r_cnt == CNT_W'(ITER_N - 1));
    assign w_dvs_zero = (r_dvs == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = BUSY;
            BUSY:    if (w_dvs_zero || w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_work starts as the dividend and fills with quotient bits from the LSB as it shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_work <= '0;
            r_dvs  <= '0;
            r_prem <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_work <= dividend;
                        r_dvs  <= divisor;
                        r_prem <= '0;
                        r_cnt  <= '0;
                        r_dbz  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (w_dvs_zero) begin
                        r_quot <= DIV0_QUOT;
                        r_rem  <= r_work[DIVISOR_W-1:0];
                        r_dbz  <= 1'b1;
                    end else begin
                        r_work <= {r_work[DIVIDEND_W-2:0], w_q_bit};
                        r_prem <= w_rem_nxt;
                        r_cnt  <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_quot <= {r_work[DIVIDEND_W-2:0], w_q_bit};
                            r_rem  <= w_rem_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);

endmodule
